fourier_analyzer: RTL

// Receive-side counterpart of the DAC Fourier synthesis path: correlates the ADC stream with one DDS
// cos/sin reference over a programmable window of samples. Emits one I/Q coefficient pair per window
// on an AXIS master, with saturation. Sits between the ADC sample stream / DDS reference and the host readout FIFO.

---
 rtl/fourier_analyzer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fourier_analyzer.sv
// rtl/fourier_analyzer.sv - windowed I/Q correlation of an ADC stream against a DDS cos/sin reference
// Three-stage pipeline (capture, multiply, accumulate) feeding a one-deep AXIS output buffer.
module fourier_analyzer #(
    parameter int ADC_WIDTH        = 14,
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int CFG_DATA_WIDTH   = 32,
    parameter int ACC_WIDTH        = 48,
    parameter int OUT_SHIFT        = 14,
    parameter int OUT_WIDTH        = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [AXIS_TDATA_WIDTH-1:0]     s_axis_adc_tdata,
    input  logic                            s_axis_adc_tvalid,
    output logic                            s_axis_adc_tready,
    input  logic [2*AXIS_TDATA_WIDTH-1:0]   s_axis_ref_tdata,
    input  logic                            s_axis_ref_tvalid,
    output logic                            s_axis_ref_tready,
    input  logic                            enable,
    input  logic [CFG_DATA_WIDTH-1:0]       period_len,
    input  logic                            clear_overrun,
    output logic [2*OUT_WIDTH-1:0]          m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            overrun
);
    localparam int TW = AXIS_TDATA_WIDTH;
    localparam int PW = 2 * AXIS_TDATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic                        s1_valid_q;
    logic signed [TW-1:0]        s1_adc_q;
    logic signed [TW-1:0]        s1_cos_q;
    logic signed [TW-1:0]        s1_sin_q;
    logic                        s2_valid_q;
    logic signed [PW-1:0]        s2_prod_i_q;
    logic signed [PW-1:0]        s2_prod_q_q;
    logic signed [ACC_WIDTH-1:0] acc_i_q;
    logic signed [ACC_WIDTH-1:0] acc_q_q;
    logic [CFG_DATA_WIDTH-1:0]   cnt_q;
    logic [CFG_DATA_WIDTH-1:0]   len_q;
    logic [2*OUT_WIDTH-1:0]      tdata_q;
    logic                        tvalid_q;
    logic                        overrun_q;

    logic                        accept;
    logic signed [TW-1:0]        adc_ext;
    logic                        unused_adc_msbs;
    logic [CFG_DATA_WIDTH-1:0]   len_cfg;
    logic [CFG_DATA_WIDTH-1:0]   len_win;
    logic [CFG_DATA_WIDTH-1:0]   cnt_d;
    logic signed [ACC_WIDTH-1:0] sum_i_d;
    logic signed [ACC_WIDTH-1:0] sum_q_d;
    logic                        result_valid;
    logic                        drop;
    logic [2*OUT_WIDTH-1:0]      tdata_d;
    logic                        tvalid_d;
    logic                        overrun_d;

    function automatic logic [OUT_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH-1:0] v;
        v = a >>> OUT_SHIFT;
        if (v > SAT_MAX)
            saturate = OUT_MAX;
        else if (v < SAT_MIN)
            saturate = OUT_MIN;
        else
            saturate = v[OUT_WIDTH-1:0];
    endfunction

    assign accept          = enable && s_axis_adc_tvalid && s_axis_ref_tvalid;
    assign adc_ext         = {{(TW-ADC_WIDTH){s_axis_adc_tdata[ADC_WIDTH-1]}}, s_axis_adc_tdata[ADC_WIDTH-1:0]};
    assign unused_adc_msbs = ^s_axis_adc_tdata[TW-1:ADC_WIDTH];
    assign len_cfg         = (period_len == '0) ? CFG_DATA_WIDTH'(1) : period_len;
    // The first product of a window compares against the live config; later ones use the latched copy.
    assign len_win         = (cnt_q == '0) ? len_cfg : len_q;
    assign sum_i_d         = acc_i_q + {{(ACC_WIDTH-PW){s2_prod_i_q[PW-1]}}, s2_prod_i_q};
    assign sum_q_d         = acc_q_q + {{(ACC_WIDTH-PW){s2_prod_q_q[PW-1]}}, s2_prod_q_q};

    always_comb begin
        cnt_d        = cnt_q + CFG_DATA_WIDTH'(1);
        result_valid = enable && s2_valid_q && (cnt_d == len_win);
        drop         = result_valid && tvalid_q && !m_axis_tready;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        if (result_valid && !drop) begin
            tdata_d  = {saturate(sum_q_d), saturate(sum_i_d)};
            tvalid_d = 1'b1;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
        overrun_d = overrun_q;
        if (clear_overrun)
            overrun_d = 1'b0;
        if (drop)
            overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_adc_q    <= '0;
            s1_cos_q    <= '0;
            s1_sin_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_prod_i_q <= '0;
            s2_prod_q_q <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_adc_q <= adc_ext;
                s1_cos_q <= s_axis_ref_tdata[TW-1:0];
                s1_sin_q <= s_axis_ref_tdata[PW-1:TW];
            end
            s2_valid_q <= s1_valid_q && enable;
            if (s1_valid_q) begin
                s2_prod_i_q <= PW'(s1_adc_q) * PW'(s1_cos_q);
                s2_prod_q_q <= PW'(s1_adc_q) * PW'(s1_sin_q);
            end
            if (!enable) begin
                acc_i_q <= '0;
                acc_q_q <= '0;
                cnt_q   <= '0;
            end else if (s2_valid_q) begin
                if (cnt_q == '0)
                    len_q <= len_cfg;
                // Closing product restarts the window directly so back-to-back windows have no gap.
                if (result_valid) begin
                    acc_i_q <= '0;
                    acc_q_q <= '0;
                    cnt_q   <= '0;
                end else begin
                    acc_i_q <= sum_i_d;
                    acc_q_q <= sum_q_d;
                    cnt_q   <= cnt_d;
                end
            end
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            overrun_q <= overrun_d;
        end
    end

    assign s_axis_adc_tready = 1'b1;
    assign s_axis_ref_tready = 1'b1;
    assign m_axis_tdata      = tdata_q;
    assign m_axis_tvalid     = tvalid_q;
    assign overrun           = overrun_q;

endmodule
